alu_issue_stage: RTL and testbench

Single-issue front end that feeds the `alu` block and consumes its result. It accepts one decoded instruction per valid/ready handshake. It reads operands from a small internal register file and drives the ALU opcode, operands and enable. It then captures the ALU result and flags, writes the result back to the destination register, and reports completion. Instructions execute strictly serially, so there are no hazards.

---
 rtl/alu_issue_stage.sv | 163 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - serial issue/writeback stage wrapped around an external ALU
module alu_issue_stage #(
  parameter int DATA_WIDTH     = 4,
  parameter int NUM_REGS       = 4,
  parameter int REG_ADDR_WIDTH = 2
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic                      instr_valid_in,
  output logic                      instr_ready_out,
  input  logic [7:0]                instr_opcode_in,
  input  logic [REG_ADDR_WIDTH-1:0] instr_rd_in,
  input  logic [REG_ADDR_WIDTH-1:0] instr_rs1_in,
  input  logic [REG_ADDR_WIDTH-1:0] instr_rs2_in,
  input  logic [DATA_WIDTH-1:0]     instr_imm_in,
  output logic                      alu_reset_out,
  output logic                      alu_enable_out,
  output logic [7:0]                alu_opcode_out,
  output logic [DATA_WIDTH-1:0]     alu_input1_out,
  output logic [DATA_WIDTH-1:0]     alu_input2_out,
  input  logic [DATA_WIDTH-1:0]     alu_result_in,
  input  logic [4:0]                alu_flags_in,
  output logic                      done_out,
  output logic                      illegal_out,
  output logic [DATA_WIDTH-1:0]     result_out,
  output logic [4:0]                flags_out,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_addr_in,
  output logic [DATA_WIDTH-1:0]     dbg_data_out
);

  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_SUB  = 8'h01;
  localparam logic [7:0] OP_EQ   = 8'h03;
  localparam logic [7:0] OP_GT   = 8'h04;
  localparam logic [7:0] OP_ADDI = 8'h09;
  localparam logic [7:0] OP_SUBI = 8'h0A;
  localparam logic [7:0] OP_MOV  = 8'h0B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // MULTIPLY (0x02) is deliberately absent: the attached ALU does not implement it.
  function automatic logic is_legal(input logic [7:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_EQ, OP_GT, OP_ADDI, OP_SUBI, OP_MOV: is_legal = 1'b1;
      default:                                                is_legal = 1'b0;
    endcase
  endfunction

  state_t                  state_q,    state_d;
  logic [7:0]              opcode_q,   opcode_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q,     rd_d;
  logic [DATA_WIDTH-1:0]   op1_q,      op1_d;
  logic [DATA_WIDTH-1:0]   op2_q,      op2_d;
  logic [DATA_WIDTH-1:0]   res_hold_q, res_hold_d;
  logic [4:0]              flg_hold_q, flg_hold_d;
  logic [DATA_WIDTH-1:0]   result_q,   result_d;
  logic [4:0]              flags_q,    flags_d;
  logic                    done_q,     done_d;
  logic                    illegal_q,  illegal_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  // Next-state and datapath: operands are read at acceptance so they are
  // flop outputs that stay stable through EXEC and hold their value afterwards.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    rd_d       = rd_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    res_hold_d = res_hold_q;
    flg_hold_d = flg_hold_q;
    result_d   = result_q;
    flags_d    = flags_q;
    regs_d     = regs_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid_in) begin
          state_d  = ST_EXEC;
          opcode_d = instr_opcode_in;
          rd_d     = instr_rd_in;
          op1_d    = regs_q[instr_rs1_in];
          if (instr_opcode_in == OP_ADDI || instr_opcode_in == OP_SUBI) begin
            op2_d = instr_imm_in;
          end else begin
            op2_d = regs_q[instr_rs2_in];
          end
        end
      end
      ST_EXEC: begin
        res_hold_d = alu_result_in;
        flg_hold_d = alu_flags_in;
        state_d    = ST_WB;
      end
      ST_WB: begin
        if (is_legal(opcode_q)) begin
          regs_d[rd_q] = res_hold_q;
          result_d     = res_hold_q;
          flags_d      = flg_hold_q;
        end else begin
          illegal_d = 1'b1;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any in-flight instruction without writeback.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= ST_IDLE;
      opcode_q   <= '0;
      rd_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      res_hold_q <= '0;
      flg_hold_q <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      rd_q       <= rd_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      res_hold_q <= res_hold_d;
      flg_hold_q <= flg_hold_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      regs_q     <= regs_d;
    end
  end

  assign instr_ready_out = (state_q == ST_IDLE);
  assign alu_enable_out  = (state_q == ST_EXEC);
  assign alu_reset_out   = reset_in;
  assign alu_opcode_out  = opcode_q;
  assign alu_input1_out  = op1_q;
  assign alu_input2_out  = op2_q;
  assign done_out        = done_q;
  assign illegal_out     = illegal_q;
  assign result_out      = result_q;
  assign flags_out       = flags_q;
  assign dbg_data_out    = regs_q[dbg_addr_in];

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       instr_valid_in;
  logic       instr_ready_out;
  logic [7:0] instr_opcode_in;
  logic [1:0] instr_rd_in, instr_rs1_in, instr_rs2_in;
  logic [3:0] instr_imm_in;
  logic       alu_reset_out, alu_enable_out;
  logic [7:0] alu_opcode_out;
  logic [3:0] alu_input1_out, alu_input2_out, alu_result_in;
  logic [4:0] alu_flags_in;
  logic       done_out, illegal_out;
  logic [3:0] result_out;
  logic [4:0] flags_out;
  logic [1:0] dbg_addr_in;
  logic [3:0] dbg_data_out;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_regs [4];
  logic [3:0] m_res;
  logic [4:0] m_flg;

  typedef struct {
    logic [7:0] op;
    logic [1:0] rd, rs1, rs2;
    logic [3:0] imm;
    logic [3:0] res;
    logic [4:0] flg;
    bit         ill;
    logic [3:0] rdv;
    bit         hold;
  } vec_t;
  vec_t vecs [11];

  alu_issue_stage #(.DATA_WIDTH(4), .NUM_REGS(4), .REG_ADDR_WIDTH(2)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
    .instr_opcode_in(instr_opcode_in), .instr_rd_in(instr_rd_in),
    .instr_rs1_in(instr_rs1_in), .instr_rs2_in(instr_rs2_in), .instr_imm_in(instr_imm_in),
    .alu_reset_out(alu_reset_out), .alu_enable_out(alu_enable_out),
    .alu_opcode_out(alu_opcode_out), .alu_input1_out(alu_input1_out),
    .alu_input2_out(alu_input2_out), .alu_result_in(alu_result_in),
    .alu_flags_in(alu_flags_in), .done_out(done_out), .illegal_out(illegal_out),
    .result_out(result_out), .flags_out(flags_out),
    .dbg_addr_in(dbg_addr_in), .dbg_data_out(dbg_data_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic int sv4(input logic [3:0] x);
    return x[3] ? int'(x) - 16 : int'(x);
  endfunction

  function automatic bit legal(input logic [7:0] op);
    return (op == 8'h00 || op == 8'h01 || op == 8'h03 || op == 8'h04 ||
            op == 8'h09 || op == 8'h0A || op == 8'h0B);
  endfunction

  // Behavioural ALU: signed/unsigned arithmetic on plain integers.
  function automatic void alu_ref(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b,
                                  output logic [3:0] r, output logic [4:0] f);
    int s;
    int u;
    logic ov, cy;
    ov = 1'b0;
    cy = 1'b0;
    case (op)
      8'h00, 8'h09: begin
        u = int'(a) + int'(b);
        s = sv4(a) + sv4(b);
        r = 4'(u);
        cy = (u > 15);
        ov = (s > 7 || s < -8);
      end
      8'h01, 8'h0A: begin
        u = int'(a) + (15 - int'(b)) + 1;
        s = sv4(a) - sv4(b);
        r = 4'(u);
        cy = (u > 15);
        ov = (s > 7 || s < -8);
      end
      8'h03:   r = (a == b) ? 4'd1 : 4'd0;
      8'h04:   r = (sv4(a) > sv4(b)) ? 4'd1 : 4'd0;
      8'h0B:   r = a;
      default: r = a ^ b ^ 4'h5;
    endcase
    f = {ov, cy, (r == 4'd0), r[3], ^r};
    if (!legal(op)) f = 5'b11111;
  endfunction

  // ALU stand-in driven from the stage's outputs.
  always_comb begin
    logic [3:0] r_t;
    logic [4:0] f_t;
    r_t = '0;
    f_t = '0;
    alu_ref(alu_opcode_out, alu_input1_out, alu_input2_out, r_t, f_t);
    alu_result_in = r_t;
    alu_flags_in  = f_t;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_instr(input logic [7:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                          input logic [1:0] rs2, input logic [3:0] imm, input bit hold,
                          input bit use_exp, input logic [3:0] e_res, input logic [4:0] e_flg,
                          input bit e_ill, input logic [3:0] e_rdv);
    logic [3:0] a, b, r;
    logic [4:0] f;
    bit ill;
    a = m_regs[rs1];
    b = (op == 8'h09 || op == 8'h0A) ? imm : m_regs[rs2];
    ill = !legal(op);
    alu_ref(op, a, b, r, f);
    if (!ill) begin
      m_regs[rd] = r;
      m_res = r;
      m_flg = f;
    end
    instr_opcode_in = op;
    instr_rd_in     = rd;
    instr_rs1_in    = rs1;
    instr_rs2_in    = rs2;
    instr_imm_in    = imm;
    instr_valid_in  = 1'b1;
    chk("ready_idle", instr_ready_out, 1);
    tick();
    chk("ready_exec", instr_ready_out, 0);
    chk("en_exec", alu_enable_out, 1);
    chk("opcode_exec", alu_opcode_out, op);
    chk("in1_exec", alu_input1_out, a);
    chk("in2_exec", alu_input2_out, b);
    chk("done_exec", done_out, 0);
    if (hold) begin
      instr_opcode_in = 8'($urandom);
      instr_rd_in     = 2'($urandom);
      instr_rs1_in    = 2'($urandom);
      instr_rs2_in    = 2'($urandom);
      instr_imm_in    = 4'($urandom);
    end else begin
      instr_valid_in = 1'b0;
    end
    tick();
    chk("ready_wb", instr_ready_out, 0);
    chk("en_wb", alu_enable_out, 0);
    chk("done_wb", done_out, 0);
    chk("in1_hold", alu_input1_out, a);
    chk("in2_hold", alu_input2_out, b);
    tick();
    chk("done_pulse", done_out, 1);
    chk("illegal", illegal_out, ill);
    chk("result", result_out, m_res);
    chk("flags", flags_out, m_flg);
    chk("ready_done", instr_ready_out, 1);
    dbg_addr_in = rd;
    #1;
    chk("reg_rd", dbg_data_out, m_regs[rd]);
    if (use_exp) begin
      chk("tbl_result", result_out, e_res);
      chk("tbl_flags", flags_out, e_flg);
      chk("tbl_illegal", illegal_out, e_ill);
      chk("tbl_rd", dbg_data_out, e_rdv);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, instr_ready_out, 1);
    chk({tag, "_done"}, done_out, 0);
    chk({tag, "_illegal"}, illegal_out, 0);
    chk({tag, "_en"}, alu_enable_out, 0);
    chk({tag, "_opcode"}, alu_opcode_out, 0);
    chk({tag, "_in1"}, alu_input1_out, 0);
    chk({tag, "_in2"}, alu_input2_out, 0);
    chk({tag, "_result"}, result_out, 0);
    chk({tag, "_flags"}, flags_out, 0);
    for (int i = 0; i < 4; i++) begin
      dbg_addr_in = 2'(i);
      #0.5;
      chk({tag, "_reg"}, dbg_data_out, 0);
    end
  endtask

  task automatic run_abort(input bit in_wb);
    instr_opcode_in = 8'h09;
    instr_rd_in     = 2'd1;
    instr_rs1_in    = 2'd0;
    instr_rs2_in    = 2'd0;
    instr_imm_in    = 4'd5;
    instr_valid_in  = 1'b1;
    tick();
    instr_valid_in = 1'b0;
    if (in_wb) tick();
    reset_in = 1'b1;
    #1;
    chk("abort_alu_reset", alu_reset_out, 1);
    check_reset_state("abort_in_reset");
    tick();
    chk("abort_done_held", done_out, 0);
    reset_in = 1'b0;
    #1;
    chk("abort_alu_release", alu_reset_out, 0);
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_res = '0;
    m_flg = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_no_done", done_out, 0);
      chk("abort_ready", instr_ready_out, 1);
    end
  endtask

  initial begin
    vecs[0]  = '{8'h09, 2'd1, 2'd0, 2'd0, 4'd7,  4'h7, 5'b00001, 1'b0, 4'h7, 1'b1};
    vecs[1]  = '{8'h00, 2'd2, 2'd1, 2'd1, 4'd0,  4'hE, 5'b10011, 1'b0, 4'hE, 1'b1};
    vecs[2]  = '{8'h01, 2'd3, 2'd0, 2'd1, 4'd0,  4'h9, 5'b00010, 1'b0, 4'h9, 1'b1};
    vecs[3]  = '{8'h04, 2'd0, 2'd2, 2'd1, 4'd0,  4'h0, 5'b00100, 1'b0, 4'h0, 1'b1};
    vecs[4]  = '{8'h03, 2'd0, 2'd1, 2'd1, 4'd0,  4'h1, 5'b00001, 1'b0, 4'h1, 1'b0};
    vecs[5]  = '{8'h02, 2'd1, 2'd1, 2'd1, 4'd0,  4'h1, 5'b00001, 1'b1, 4'h7, 1'b0};
    vecs[6]  = '{8'h0A, 2'd2, 2'd1, 2'd0, 4'd3,  4'h4, 5'b01001, 1'b0, 4'h4, 1'b1};
    vecs[7]  = '{8'h0B, 2'd3, 2'd2, 2'd0, 4'd0,  4'h4, 5'b00001, 1'b0, 4'h4, 1'b0};
    vecs[8]  = '{8'hFF, 2'd0, 2'd3, 2'd3, 4'd0,  4'h4, 5'b00001, 1'b1, 4'h1, 1'b0};
    vecs[9]  = '{8'h09, 2'd0, 2'd3, 2'd0, 4'hC,  4'h0, 5'b01100, 1'b0, 4'h0, 1'b1};
    vecs[10] = '{8'h00, 2'd1, 2'd1, 2'd1, 4'd0,  4'hE, 5'b10011, 1'b0, 4'hE, 1'b0};

    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_res = '0;
    m_flg = '0;
    reset_in        = 1'b1;
    instr_valid_in  = 1'b0;
    instr_opcode_in = '0;
    instr_rd_in     = '0;
    instr_rs1_in    = '0;
    instr_rs2_in    = '0;
    instr_imm_in    = '0;
    dbg_addr_in     = '0;
    #2;
    chk("reset_alu_reset", alu_reset_out, 1);
    check_reset_state("reset");
    tick();
    tick();
    reset_in = 1'b0;
    #1;
    chk("release_alu_reset", alu_reset_out, 0);
    check_reset_state("post_reset");

    for (int i = 0; i < 11; i++) begin
      do_instr(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].hold,
               1'b1, vecs[i].res, vecs[i].flg, vecs[i].ill, vecs[i].rdv);
    end

    run_abort(1'b0);
    do_instr(8'h09, 2'd2, 2'd0, 2'd0, 4'd3, 1'b0, 1'b1, 4'h3, 5'b00000, 1'b0, 4'h3);
    run_abort(1'b1);

    for (int n = 0; n < 60; n++) begin
      logic [7:0] op;
      int sel;
      sel = $urandom_range(0, 8);
      case (sel)
        0: op = 8'h00;
        1: op = 8'h01;
        2: op = 8'h02;
        3: op = 8'h03;
        4: op = 8'h04;
        5: op = 8'h09;
        6: op = 8'h0A;
        7: op = 8'h0B;
        default: op = 8'($urandom);
      endcase
      do_instr(op, 2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom),
               (n != 59) && ($urandom_range(0, 1) == 1), 1'b0, '0, '0, 1'b0, '0);
      if (!instr_valid_in) begin
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    instr_valid_in = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      dbg_addr_in = 2'(i);
      #1;
      chk("final_reg", dbg_data_out, m_regs[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
